tdm_mux16: RTL
==============

TDM_MUX16 -- requirements
Module: tdm_mux16

Interface
REQ-001 The module SHALL have parameter HOLD_CYCLES, default 1, setting the clock cycles each channel is presented (legal range 1..16).
REQ-002 The module SHALL have parameter DESCEND, default 0: 0 scans channel 0..15, 1 scans channel 15..0.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port start, input, 1 bit: frame request.
REQ-006 The module SHALL have ports d0..d15, input, 1 bit each: parallel channel data.
REQ-007 The module SHALL have port z0, output, 1 bit: serial data of the current channel.
REQ-008 The module SHALL have ports s0..s3, output, 1 bit each: current channel index (s0 = LSB), matching the select inputs of a downstream 1:16 demultiplexer.
REQ-009 The module SHALL have port valid, output, 1 bit: z0/s0..s3 carry frame data.
REQ-010 The module SHALL have port busy, output, 1 bit: frame in progress.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle end-of-frame pulse.

Function
REQ-012 The module SHALL implement FSM states IDLE, SHIFT, DONE with a 16-bit snapshot register, a 4-bit channel index and a 4-bit hold counter.
REQ-013 All outputs SHALL be decoded from registers only; there SHALL be no combinational path from any input to any output.
REQ-014 In IDLE, the module SHALL drive z0, s0..s3, valid, busy and done to 0.
REQ-015 In IDLE, start=1 at an edge SHALL load d15..d0 into the snapshot, set index to 0 (15 if DESCEND=1), clear the hold counter and enter SHIFT.
REQ-016 In SHIFT, the module SHALL drive valid=1, busy=1, s3..s0=index and z0=snapshot[index].
REQ-017 In SHIFT, each edge SHALL increment the hold counter; when it equals HOLD_CYCLES-1, the module SHALL clear it and step the index by +1 (-1 if DESCEND=1).
REQ-018 After the last hold cycle of the final channel (15, or 0 if DESCEND=1), the next state SHALL be DONE; the index SHALL NOT wrap into a second pass.
REQ-019 In DONE, the module SHALL drive done=1 and valid=busy=z0=s0..s3=0, then enter IDLE unconditionally on the next edge.
REQ-020 Latency: for start sampled at edge N, valid SHALL be 1 for exactly 16*HOLD_CYCLES cycles following edge N, and done SHALL be 1 in the single cycle after edge N+16*HOLD_CYCLES.
REQ-021 start in SHIFT or DONE SHALL be ignored; no frame SHALL be queued.
REQ-022 Changes on d0..d15 after the capture edge SHALL NOT affect the current frame.
REQ-023 With start held high continuously, frames SHALL repeat with exactly one DONE cycle and one IDLE cycle between the last valid cycle and the first valid cycle of the next frame.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, clear the snapshot, index and hold counter, and drive all outputs 0 in the following cycle, overriding start.
REQ-025 rst during SHIFT SHALL abort the frame without asserting done.
REQ-026 The first start sampled after rst deasserts SHALL begin a normal frame.

Verification
REQ-027 The bench SHALL check reset: rst=1 for 2 cycles with start=1 and all d=1 -> z0, s0..s3, valid, busy and done all 0.
REQ-028 The bench SHALL check a basic frame: HOLD_CYCLES=1, DESCEND=0, d15..d0=16'hA5C3, one-cycle start at edge 0 -> cycles 1..16 valid=1 with s=0..15, z0 sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; done=1 in cycle 17; IDLE in cycle 18.
REQ-029 The bench SHALL check snapshot and start filtering: same frame, d forced to 0 and start pulsed at s=5 -> z0 sequence unchanged; no second frame.
REQ-030 The bench SHALL check hold: HOLD_CYCLES=3 -> each index held 3 cycles; valid for 48 cycles; done in cycle 49.
REQ-031 The bench SHALL check descending order: DESCEND=1, d=16'h8001 -> s runs 15..0; z0=1 in the first and last valid cycles only.
REQ-032 The bench SHALL check mid-frame reset: rst at s=7 -> next cycle all outputs 0 and no done pulse; a start two cycles later produces a full 16-channel frame.

Source files
------------

// File: rtl/tdm_mux16.sv
// rtl/tdm_mux16.sv - 16:1 time-division multiplexer with snapshot, hold and channel index outputs
module tdm_mux16 #(
    parameter int HOLD_CYCLES = 1,
    parameter int DESCEND     = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic d8,
    input  logic d9,
    input  logic d10,
    input  logic d11,
    input  logic d12,
    input  logic d13,
    input  logic d14,
    input  logic d15,
    output logic z0,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic valid,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] IDX_FIRST = (DESCEND != 0) ? 4'd15 : 4'd0;
    localparam logic [3:0] IDX_LAST  = (DESCEND != 0) ? 4'd0  : 4'd15;

    state_t      state_q, state_d;
    logic [15:0] snap_q, snap_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  hold_q, hold_d;
    logic        z_q, z_d;
    logic [3:0]  s_q, s_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Next-state logic; outputs are precomputed from the next state so they leave flops directly
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = {d15, d14, d13, d12, d11, d10, d9, d8,
                               d7, d6, d5, d4, d3, d2, d1, d0};
                    idx_d   = IDX_FIRST;
                    hold_d  = 4'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = 4'd0;
                    if (idx_q == IDX_LAST) begin
                        // Single pass only: stay on the last channel and finish
                        state_d = DONE;
                    end else if (DESCEND != 0) begin
                        idx_d = idx_q - 4'd1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        z_d     = 1'b0;
        s_d     = 4'd0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            SHIFT: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                s_d     = idx_d;
                z_d     = snap_d[idx_d];
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset overriding start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= 16'd0;
            idx_q   <= 4'd0;
            hold_q  <= 4'd0;
            z_q     <= 1'b0;
            s_q     <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            z_q     <= z_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign z0    = z_q;
    assign s0    = s_q[0];
    assign s1    = s_q[1];
    assign s2    = s_q[2];
    assign s3    = s_q[3];
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
